fpu_issue_queue: RTL and testbench

- Instruction buffer and RAW-hazard scoreboard sitting directly upstream of the 4-stage FPU pipeline.
- Accepts FP instruction words from the core through a valid/ready handshake and buffers them in a FIFO.
- Drives the FPU `instruction` input with one word per cycle, inserting a bubble whenever the head instruction reads a register still in flight.
- The FPU pipeline has no interlocks; this block guarantees every source operand is read only after its producer has written back.

---
 rtl/fpu_issue_queue.sv | 202 ++++++++++++++++++++
 tb/tb_fpu_issue_queue.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_queue.sv
// Purpose: buffers FP instruction words and issues them to the FPU, holding a RAW-dependent head until its producer has written back.
// Latency: a word pushed into an empty, hazard-free queue appears on `instruction` one edge later; dependent issue is spaced PIPE_LAT edges from its producer.
// Backpressure: ins_ready drops when the queue holds DEPTH words; a stalled head blocks all younger words.
// Optional build macro FPU_ISSUE_PERF_EN enables the saturating stall_cycles counter (tied to zero otherwise).
module fpu_issue_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PIPE_LAT = 5,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_valid,
  input  logic [31:0] ins_data,
  output logic        ins_ready,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic        issue_valid,
  output logic        drop_pulse,
  output logic [15:0] stall_cycles
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SB = PIPE_LAT - 1;

  // FIFO storage and bookkeeping
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          push;

  // In-flight destination registers, position 0 is the youngest
  logic [SB-1:0] sb_vld;
  logic [4:0]    sb_rd [SB];

  // Head decode
  logic [31:0] head;
  logic [4:0]  head_rs1;
  logic [4:0]  head_rs2;
  logic [4:0]  head_rs3;
  logic [4:0]  head_rd;
  logic [4:0]  head_funct5;
  logic        is_r4;
  logic        is_opfp;
  logic        is_fp;
  logic        is_unary;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rs3;
  logic        hazard;

  // Issue decisions for this edge
  logic do_pop;
  logic do_issue;
  logic do_drop;

  assign empty     = (count == '0);
  assign ins_ready = (count != CW'(DEPTH));
  // A word offered alongside flush is dropped rather than queued.
  assign push      = ins_valid && ins_ready && !flush;

  assign head        = mem[rd_ptr];
  assign head_rd     = head[11:7];
  assign head_rs1    = head[19:15];
  assign head_rs2    = head[24:20];
  assign head_rs3    = head[31:27];
  assign head_funct5 = head[31:27];
  assign is_r4       = (head[6:4] == 3'b100);
  assign is_opfp     = (head[6:4] == 3'b101);
  assign is_fp       = is_r4 || is_opfp;

  // Single-source OP-FP forms (sqrt, class, the int/FP conversions and moves) ignore the rs2 field.
  always_comb begin
    is_unary = 1'b0;
    case (head_funct5)
      5'b01011, 5'b11100, 5'b11000, 5'b11010, 5'b11110: is_unary = 1'b1;
      default:                                          is_unary = 1'b0;
    endcase
  end

  assign use_rs1 = is_fp;
  assign use_rs2 = is_r4 || (is_opfp && !is_unary);
  assign use_rs3 = is_r4;

  // Compare every in-flight destination against each source the head really reads; f0 is not special.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB; i++) begin
      if (sb_vld[i] &&
          ((use_rs1 && (sb_rd[i] == head_rs1)) ||
           (use_rs2 && (sb_rd[i] == head_rs2)) ||
           (use_rs3 && (sb_rd[i] == head_rs3)))) begin
        hazard = 1'b1;
      end
    end
  end

  // Per-edge issue priority: flush, empty, non-FP drop, hazard stall, issue.
  always_comb begin
    do_pop   = 1'b0;
    do_issue = 1'b0;
    do_drop  = 1'b0;
    if (flush) begin
      do_pop = 1'b0;
    end else if (empty) begin
      do_pop = 1'b0;
    end else if (!is_fp) begin
      do_pop  = 1'b1;
      do_drop = 1'b1;
    end else if (hazard) begin
      do_pop = 1'b0;
    end else begin
      do_pop   = 1'b1;
      do_issue = 1'b1;
    end
  end

  // Word storage; pointers alone define validity so the array needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= ins_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Scoreboard shifts every edge, including during flush, so in-flight producers keep protecting later consumers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_vld <= '0;
      for (int i = 0; i < SB; i++) begin
        sb_rd[i] <= 5'd0;
      end
    end else begin
      sb_vld[0] <= do_issue;
      sb_rd[0]  <= head_rd;
      for (int i = 1; i < SB; i++) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_rd[i]  <= sb_rd[i-1];
      end
    end
  end

  // Registered FPU-facing outputs; anything other than a real issue presents the bubble word.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= NOP_WORD;
      issue_valid <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      instruction <= do_issue ? head : NOP_WORD;
      issue_valid <= do_issue;
      drop_pulse  <= do_drop;
    end
  end

`ifdef FPU_ISSUE_PERF_EN
  logic        do_stall;
  logic [15:0] stall_q;

  assign do_stall = !flush && !empty && is_fp && hazard;

  // Saturating count of hazard-stall edges; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'h0000;
    end else if (do_stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue: table of producer/consumer hazard pairs plus hand sequences.
// Inputs change 1ns after posedge; outputs are sampled at the same point.
// Expected stall counter values follow the FPU_ISSUE_PERF_EN build setting.
module tb_fpu_issue_queue;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] INT_ADDI = 32'h0000_0013;

  localparam logic [4:0] F_ADD   = 5'b00000;
  localparam logic [4:0] F_MUL   = 5'b00010;
  localparam logic [4:0] F_SQRT  = 5'b01011;
  localparam logic [4:0] F_CLASS = 5'b11100;
  localparam logic [4:0] F_CVTWS = 5'b11000;
  localparam logic [4:0] F_CVTSW = 5'b11010;
  localparam logic [4:0] F_MVWX  = 5'b11110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_valid = 1'b0;
  logic [31:0] ins_data = 32'h0;
  logic        ins_ready;
  logic        flush = 1'b0;
  logic [31:0] instruction;
  logic        issue_valid;
  logic        drop_pulse;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  fpu_issue_queue #(.DEPTH(4), .PIPE_LAT(5), .NOP_WORD(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .ins_valid    (ins_valid),
    .ins_data     (ins_data),
    .ins_ready    (ins_ready),
    .flush        (flush),
    .instruction  (instruction),
    .issue_valid  (issue_valid),
    .drop_pulse   (drop_pulse),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] opfp(input logic [4:0] f5, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {f5, 2'b00, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] r4(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rs3);
    return {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'b1000011};
  endfunction

  function automatic int exp_st(input int n);
`ifdef FPU_ISSUE_PERF_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_issue(input string nm, input logic [31:0] w);
    chk(nm, instruction, w);
    chk({nm, "_valid"}, 32'(issue_valid), 32'd1);
  endtask

  task automatic chk_bubble(input string nm);
    chk(nm, instruction, NOP);
    chk({nm, "_valid"}, 32'(issue_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ins_valid = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] prod;
    logic [31:0] cons;
    int          stalls;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  logic [31:0] w [4];
  logic [31:0] p0, c0, w1, w2, w3, xw, c2;
  int nops;
  int found;

  initial begin
    // producer / consumer / expected bubble cycles between them (PIPE_LAT-1 = 4 on a hit)
    vecs[0]  = '{opfp(F_ADD, 5'd3, 5'd1, 5'd2),  opfp(F_MUL, 5'd8, 5'd1, 5'd3),   4};
    vecs[1]  = '{opfp(F_ADD, 5'd3, 5'd1, 5'd2),  opfp(F_ADD, 5'd8, 5'd3, 5'd1),   4};
    vecs[2]  = '{opfp(F_ADD, 5'd7, 5'd1, 5'd2),  r4(5'd9, 5'd1, 5'd2, 5'd7),       4};
    vecs[3]  = '{opfp(F_ADD, 5'd7, 5'd1, 5'd2),  opfp(F_SQRT, 5'd9, 5'd1, 5'd7),  0};
    vecs[4]  = '{opfp(F_ADD, 5'd7, 5'd1, 5'd2),  opfp(F_CVTSW, 5'd9, 5'd2, 5'd7), 0};
    vecs[5]  = '{opfp(F_ADD, 5'd0, 5'd1, 5'd2),  opfp(F_ADD, 5'd5, 5'd0, 5'd3),   4};
    vecs[6]  = '{opfp(F_ADD, 5'd9, 5'd1, 5'd2),  opfp(F_ADD, 5'd5, 5'd1, 5'd2),   0};
    vecs[7]  = '{opfp(F_ADD, 5'd4, 5'd1, 5'd2),  opfp(F_CLASS, 5'd5, 5'd4, 5'd0), 4};
    vecs[8]  = '{opfp(F_ADD, 5'd4, 5'd1, 5'd2),  opfp(F_MVWX, 5'd5, 5'd4, 5'd0),  4};
    vecs[9]  = '{opfp(F_ADD, 5'd4, 5'd1, 5'd2),  opfp(F_CVTWS, 5'd5, 5'd1, 5'd4), 0};
    vecs[10] = '{opfp(F_MUL, 5'd6, 5'd1, 5'd2),  r4(5'd9, 5'd1, 5'd6, 5'd3),       4};

    // Reset state
    do_reset();
    chk("rst_instruction", instruction, NOP);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("rst_ins_ready", 32'(ins_ready), 32'd1);

    // Hazard table: producer pushed at edge 1 and issued at edge 2, consumer pushed at edge 2
    for (int v = 0; v < NV; v++) begin
      do_reset();
      ins_valid = 1'b1;
      ins_data = vecs[v].prod;
      tick();
      ins_data = vecs[v].cons;
      tick();
      ins_valid = 1'b0;
      chk_issue($sformatf("vec%0d_prod", v), vecs[v].prod);
      nops = 0;
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
        tick();
        if (issue_valid && instruction == vecs[v].cons) found = 1;
        else nops++;
      end
      chk($sformatf("vec%0d_cons_issued", v), 32'(found), 32'd1);
      chk($sformatf("vec%0d_bubbles", v), 32'(nops), 32'(vecs[v].stalls));
      chk($sformatf("vec%0d_stall_cycles", v), 32'(stall_cycles), 32'(exp_st(vecs[v].stalls)));
    end

    // Independent stream: pushes at edges 1-4, issues at edges 2-5
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = opfp(F_ADD, 5'(10 + i), 5'(20 + i), 5'(25 + i));
    ins_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ins_data = w[i];
      tick();
      if (i > 0) chk_issue($sformatf("stream_w%0d", i - 1), w[i-1]);
    end
    ins_valid = 1'b0;
    tick();
    chk_issue("stream_w3", w[3]);
    tick();
    chk_bubble("stream_idle");
    chk("stream_stall_cycles", 32'(stall_cycles), 32'd0);

    // Full / backpressure with stalled head
    do_reset();
    p0 = opfp(F_ADD, 5'd3, 5'd1, 5'd2);
    c0 = opfp(F_MUL, 5'd8, 5'd1, 5'd3);
    for (int i = 0; i < 4; i++) w[i] = opfp(F_ADD, 5'(12 + i), 5'(16 + i), 5'(20 + i));
    ins_valid = 1'b1;
    ins_data = p0;
    tick();
    ins_data = c0;
    tick();
    chk_issue("bp_prod", p0);
    for (int i = 0; i < 3; i++) begin
      ins_data = w[i];
      tick();
    end
    chk("bp_full_ready", 32'(ins_ready), 32'd0);
    ins_data = w[3];
    tick();
    chk("bp_still_full", 32'(ins_ready), 32'd0);
    chk_bubble("bp_stall");
    tick();
    chk_issue("bp_cons", c0);
    chk("bp_ready_after_pop", 32'(ins_ready), 32'd1);
    tick();
    ins_valid = 1'b0;
    chk_issue("bp_w0", w[0]);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_issue($sformatf("bp_w%0d", i), w[i]);
    end
    tick();
    chk_bubble("bp_no_dup");
    chk("bp_stall_cycles", 32'(stall_cycles), 32'(exp_st(4)));

    // Non-FP drop and pointer wrap
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ins_valid = 1'b1;
      ins_data = INT_ADDI;
      tick();
      ins_data = opfp(F_ADD, 5'(10 + k), 5'd1, 5'd2);
      tick();
      ins_valid = 1'b0;
      chk($sformatf("drop%0d_pulse", k), 32'(drop_pulse), 32'd1);
      chk_bubble($sformatf("drop%0d_bubble", k));
      tick();
      chk_issue($sformatf("drop%0d_fadd", k), opfp(F_ADD, 5'(10 + k), 5'd1, 5'd2));
      chk($sformatf("drop%0d_pulse_clear", k), 32'(drop_pulse), 32'd0);
    end
    tick();
    chk_bubble("drop_no_dup");

    // Flush with stalled head; scoreboard keeps protecting f9 afterwards
    do_reset();
    p0 = opfp(F_ADD, 5'd5, 5'd1, 5'd2);
    c0 = opfp(F_MUL, 5'd9, 5'd5, 5'd2);
    w1 = opfp(F_ADD, 5'd10, 5'd9, 5'd3);
    w2 = opfp(F_ADD, 5'd11, 5'd1, 5'd2);
    w3 = opfp(F_ADD, 5'd12, 5'd1, 5'd2);
    xw = opfp(F_ADD, 5'd13, 5'd1, 5'd2);
    c2 = opfp(F_ADD, 5'd14, 5'd3, 5'd9);
    ins_valid = 1'b1;
    ins_data = p0;
    tick();
    ins_data = c0;
    tick();
    chk_issue("fl_prod", p0);
    ins_data = w1;
    tick();
    ins_data = w2;
    tick();
    ins_data = w3;
    tick();
    ins_valid = 1'b0;
    tick();
    tick();
    chk_issue("fl_c0", c0);
    flush = 1'b1;
    ins_valid = 1'b1;
    ins_data = xw;
    tick();
    flush = 1'b0;
    ins_valid = 1'b0;
    chk("fl_ready", 32'(ins_ready), 32'd1);
    chk_bubble("fl_bubble");
    chk("fl_stall_kept", 32'(stall_cycles), 32'(exp_st(4)));
    ins_valid = 1'b1;
    ins_data = c2;
    tick();
    ins_valid = 1'b0;
    chk_bubble("fl_empty");
    tick();
    chk_bubble("fl_sb_block1");
    tick();
    chk_bubble("fl_sb_block2");
    tick();
    chk_issue("fl_c2", c2);
    tick();
    chk_bubble("fl_no_stale");
    chk("fl_stall_cycles", 32'(stall_cycles), 32'(exp_st(6)));

    // Reset mid-stream
    do_reset();
    ins_valid = 1'b1;
    ins_data = p0;
    tick();
    ins_data = c0;
    tick();
    ins_data = w2;
    tick();
    ins_valid = 1'b0;
    tick();
    rst = 1'b1;
    ins_valid = 1'b1;
    ins_data = xw;
    tick();
    rst = 1'b0;
    ins_valid = 1'b0;
    chk("mrst_instruction", instruction, NOP);
    chk("mrst_issue_valid", 32'(issue_valid), 32'd0);
    chk("mrst_drop_pulse", 32'(drop_pulse), 32'd0);
    chk("mrst_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("mrst_ins_ready", 32'(ins_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mrst_quiet%0d", i), 32'(issue_valid), 32'd0);
    end

    // Reset clears the scoreboard: dependent word issues without waiting
    ins_valid = 1'b1;
    ins_data = p0;
    tick();
    ins_valid = 1'b0;
    tick();
    chk_issue("sbrst_prod", p0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ins_valid = 1'b1;
    ins_data = c0;
    tick();
    ins_valid = 1'b0;
    tick();
    chk_issue("sbrst_cons", c0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
